// File: rtl/fpu_fclass.sv
// Two-stage pipelined FCLASS: field decode, then one-hot RISC-V class mask.
// Optional build macro FCLASS_NANBOX_EN: treat improperly NaN-boxed singles as canonical qNaN.
module fpu_fclass #(
    parameter int BUS_WIDTH = 64,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_fmt,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0] out_tag
);

    logic d_sign, d_exp_ones, d_exp_zero, d_man_zero, d_man_msb;

    logic                 s1_valid;
    logic                 s1_sign, s1_exp_ones, s1_exp_zero, s1_man_zero, s1_man_msb;
    logic [TAG_WIDTH-1:0] s1_tag;

    logic                 s2_valid;
    logic [9:0]           s2_mask;
    logic [TAG_WIDTH-1:0] s2_tag;

    logic                 s2_load;
    logic                 s1_advance;
    logic                 in_fire;
    logic [9:0]           c_mask;

    generate
        if (BUS_WIDTH >= 64) begin : g_dbl
            always_comb begin
                if (in_fmt) begin
                    d_sign     = in_data[63];
                    d_exp_ones = &in_data[62:52];
                    d_exp_zero = ~|in_data[62:52];
                    d_man_zero = ~|in_data[51:0];
                    d_man_msb  = in_data[51];
                end else begin
                    d_sign     = in_data[31];
                    d_exp_ones = &in_data[30:23];
                    d_exp_zero = ~|in_data[30:23];
                    d_man_zero = ~|in_data[22:0];
                    d_man_msb  = in_data[22];
                end
`ifdef FCLASS_NANBOX_EN
                // A single without an all-ones upper word reads as the canonical qNaN.
                if (!in_fmt && !(&in_data[63:32])) begin
                    d_sign     = 1'b0;
                    d_exp_ones = 1'b1;
                    d_exp_zero = 1'b0;
                    d_man_zero = 1'b0;
                    d_man_msb  = 1'b1;
                end
`endif
            end
        end else begin : g_sgl
            always_comb begin
                d_sign     = in_data[31];
                d_exp_ones = &in_data[30:23];
                d_exp_zero = ~|in_data[30:23];
                d_man_zero = ~|in_data[22:0];
                d_man_msb  = in_data[22];
            end
        end
    endgenerate

    assign s2_load    = !s2_valid || out_ready;
    assign s1_advance = s2_load;
    assign in_ready   = !s1_valid || s1_advance;
    assign in_fire    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
        if (in_fire) begin
            s1_sign     <= d_sign;
            s1_exp_ones <= d_exp_ones;
            s1_exp_zero <= d_exp_zero;
            s1_man_zero <= d_man_zero;
            s1_man_msb  <= d_man_msb;
            s1_tag      <= in_tag;
        end
    end

    always_comb begin
        c_mask    = '0;
        c_mask[0] = s1_sign  && s1_exp_ones && s1_man_zero;
        c_mask[1] = s1_sign  && !s1_exp_ones && !s1_exp_zero;
        c_mask[2] = s1_sign  && s1_exp_zero && !s1_man_zero;
        c_mask[3] = s1_sign  && s1_exp_zero && s1_man_zero;
        c_mask[4] = !s1_sign && s1_exp_zero && s1_man_zero;
        c_mask[5] = !s1_sign && s1_exp_zero && !s1_man_zero;
        c_mask[6] = !s1_sign && !s1_exp_ones && !s1_exp_zero;
        c_mask[7] = !s1_sign && s1_exp_ones && s1_man_zero;
        c_mask[8] = s1_exp_ones && !s1_man_zero && !s1_man_msb;
        c_mask[9] = s1_exp_ones && s1_man_msb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mask  <= '0;
            s2_tag   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mask <= c_mask;
                s2_tag  <= s1_tag;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = {{(BUS_WIDTH-10){1'b0}}, s2_mask};
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_fpu_fclass.sv
// Scoreboard bench for fpu_fclass: directed classes, streaming, backpressure, random, reset.
module tb_fpu_fclass;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_fmt;
    logic [63:0] in_data;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_tag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_out = 0;
    int n_acc = 0;
    int first_cyc = 0;
    int last_cyc = 0;

    logic [63:0] exp_data_q[$];
    logic [4:0]  exp_tag_q[$];

    logic        held = 1'b0;
    logic [63:0] held_data;
    logic [4:0]  held_tag;

    fpu_fclass #(.BUS_WIDTH(64), .TAG_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] model(input logic [63:0] d, input logic f);
        logic        s, q;
        logic [10:0] e, emax;
        logic [51:0] m;
`ifdef FCLASS_NANBOX_EN
        if (!f && d[63:32] != 32'hFFFF_FFFF) return 10'h200;
`endif
        if (f) begin
            s = d[63]; e = d[62:52]; m = d[51:0]; emax = 11'h7FF; q = d[51];
        end else begin
            s = d[31]; e = {3'b0, d[30:23]}; m = {29'b0, d[22:0]}; emax = 11'h0FF; q = d[22];
        end
        if (e == emax) begin
            if (m == 0) return s ? 10'h001 : 10'h080;
            return q ? 10'h200 : 10'h100;
        end
        if (e == 0) begin
            if (m == 0) return s ? 10'h008 : 10'h010;
            return s ? 10'h004 : 10'h020;
        end
        return s ? 10'h002 : 10'h040;
    endfunction

    // Monitor: transfers are decided by values that are stable from negedge to the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", {63'b0, out_valid}, 64'd1);
                check("stall_data", out_data, held_data);
                check("stall_tag", {59'b0, out_tag}, {59'b0, held_tag});
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            held_tag = out_tag;
            if (out_valid && out_ready) begin
                if (n_out == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_out++;
                if (exp_data_q.size() == 0) begin
                    check("unexpected_output", out_data, 64'hDEAD);
                end else begin
                    check("out_data", out_data, exp_data_q.pop_front());
                    check("out_tag", {59'b0, out_tag}, {59'b0, exp_tag_q.pop_front()});
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                exp_data_q.push_back({54'b0, model(in_data, in_fmt)});
                exp_tag_q.push_back(in_tag);
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic f, input logic [4:0] t,
                        input logic keep, input logic rnd);
        logic got;
        got = 1'b0;
        in_valid = 1'b1; in_data = d; in_fmt = f; in_tag = t;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (got) break;
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_data_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!done) check("drain_timeout", 64'(exp_data_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: v[62:52] = '1;
            1: v[62:52] = '0;
            2: v[30:23] = '1;
            3: v[30:23] = '0;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) v[51:0] = '0;
        if ($urandom_range(0, 3) == 0) v[22:0] = '0;
        return v;
    endfunction

    logic [63:0] dvec[10] = '{64'hFFF0000000000000, 64'hBFF0000000000000, 64'h800FFFFFFFFFFFFF,
                              64'h8000000000000000, 64'h0000000000000000, 64'h0008000000000000,
                              64'h3FF0000000000000, 64'h7FF0000000000000, 64'h7FF4000000000000,
                              64'h7FF8000000000000};
    logic [31:0] svec[4] = '{32'h7F800000, 32'h00400000, 32'hFFC00000, 32'h7FA00000};
    logic [9:0]  smask[4] = '{10'h080, 10'h020, 10'h200, 10'h100};

    initial begin
        int a0;
        logic a;
        rst = 1'b1; in_valid = 1'b0; in_fmt = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_tag", {59'b0, out_tag}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Directed doubles: out_valid low one cycle after accept, high the next.
        for (int i = 0; i < 10; i++) begin
            check("model_vec", {54'b0, model(dvec[i], 1'b1)}, 64'd1 << i);
            send(dvec[i], 1'b1, 5'(i + 3), 1'b0, 1'b0);
            @(negedge clk);
            check("lat_n1", {63'b0, out_valid}, 64'd0);
            @(negedge clk);
            check("lat_n2", {63'b0, out_valid}, 64'd1);
            check("lat_data", out_data, 64'd1 << i);
            @(posedge clk); #1;
        end
        wait_empty(20);

        // Back-to-back NaN-boxed singles at full rate.
        n_out = 0;
        for (int i = 0; i < 16; i++)
            send({32'hFFFF_FFFF, svec[i % 4]}, 1'b0, 5'(i), 1'b1, 1'b0);
        in_valid = 1'b0;
        wait_empty(20);
        check("stream_count", 64'(n_out), 64'd16);
        check("stream_rate", 64'(last_cyc - first_cyc), 64'd15);
        check("model_single", {54'b0, model({32'hFFFF_FFFF, svec[2]}, 1'b0)}, {54'b0, smask[2]});

        // Backpressure with in_valid held high.
        a0 = n_acc;
        out_ready = 1'b0;
        in_valid = 1'b1; in_fmt = 1'b1; in_data = dvec[6]; in_tag = 5'd20;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk); #1;
            if (a) begin
                in_tag = in_tag + 5'd1;
                in_data = dvec[(i + 1) % 10];
            end
        end
        @(negedge clk);
        check("bp_accepts", 64'(n_acc - a0), 64'd2);
        check("bp_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        wait_empty(20);

        // Random traffic.
        a0 = n_acc;
        for (int i = 0; i < 1000; i++) begin
            send(rnd_operand(), 1'($urandom_range(0, 1)), 5'($urandom), 1'b0, 1'b1);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        out_ready = 1'b1;
        wait_empty(100);
        check("rand_accepts", 64'(n_acc - a0), 64'd1000);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(dvec[1], 1'b1, 5'd7, 1'b0, 1'b0);
        send(dvec[2], 1'b1, 5'd8, 1'b0, 1'b0);
        @(negedge clk);
        check("full_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_data_q.delete();
        exp_tag_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Improperly boxed single.
        send(64'h000000003F800000, 1'b0, 5'd30, 1'b0, 1'b0);
        wait_empty(20);
`ifdef FCLASS_NANBOX_EN
        check("nanbox_model", {54'b0, model(64'h000000003F800000, 1'b0)}, 64'h200);
`else
        check("nanbox_model", {54'b0, model(64'h000000003F800000, 1'b0)}, 64'h040);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
